// File: rtl/dummy_accelerator_mq.sv
// dummy_accelerator_mq
//    Multi-outstanding dummy coprocessor for the X-interface path. Each
//    accepted operation has its result computed immediately. The result is
//    stored in a circular buffer together with its tag and a latency
//    countdown. Results leave strictly in order, once the head entry's
//    countdown has reached zero.
//
// Ports
//    clk_i        clock, rising edge
//    rst_i        synchronous reset, active-high (priority over flush_i)
//    flush_i      synchronous clear of all in-flight entries
//    valid_i      upstream request valid
//    ready_o      upstream ready (buffer not full)
//    rs1_value_i  operand
//    imm_i        immediate, zero-extended to WIDTH
//    op_i         00 XOR, 01 ADD, 10 SUB, 11 ROTL
//    lat_i        extra wait cycles before the result may be released
//    tag_i        request tag, returned with the result
//    valid_o      head result valid
//    ready_i      downstream ready
//    result_o     head result (0 when valid_o is low)
//    tag_o        head tag (0 when valid_o is low)
//    occupancy_o  number of valid entries

module dummy_accelerator_mq #(
   parameter int WIDTH     = 32,
   parameter int IMM_WIDTH = 11,
   parameter int DEPTH     = 4,
   parameter int LAT_WIDTH = 6,
   parameter int TAG_WIDTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  logic [WIDTH-1:0]           rs1_value_i,
   input  logic [IMM_WIDTH-1:0]       imm_i,
   input  logic [1:0]                 op_i,
   input  logic [LAT_WIDTH-1:0]       lat_i,
   input  logic [TAG_WIDTH-1:0]       tag_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [WIDTH-1:0]           result_o,
   output logic [TAG_WIDTH-1:0]       tag_o,
   output logic [$clog2(DEPTH):0]     occupancy_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam int SH_W  = $clog2(WIDTH);
   localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

   logic [WIDTH-1:0]     res_mem [DEPTH];
   logic [TAG_WIDTH-1:0] tag_mem [DEPTH];
   logic [LAT_WIDTH-1:0] cnt_mem [DEPTH];
   logic [DEPTH-1:0]     vld;

   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [OCC_W-1:0]     occ;

   logic                 push;
   logic                 pop;
   logic                 head_rdy;
   logic                 clear;
   logic [WIDTH-1:0]     immz;
   logic [WIDTH-1:0]     op_res;
   logic [2*WIDTH-1:0]   rot_dbl;

   // ------------------------------------------------------------------
   // Result arithmetic, evaluated at accept time
   // ------------------------------------------------------------------
   assign immz = {{(WIDTH-IMM_WIDTH){1'b0}}, imm_i};

   // Rotate-left: the upper half of the doubled operand shifted left holds
   // the rotated word; only the low SH_W immediate bits act as the amount.
   assign rot_dbl = {rs1_value_i, rs1_value_i} << imm_i[SH_W-1:0];

   always_comb begin
      op_res = rs1_value_i ^ immz;
      case (op_i)
         2'b00:   op_res = rs1_value_i ^ immz;
         2'b01:   op_res = rs1_value_i + immz;
         2'b10:   op_res = rs1_value_i - immz;
         default: op_res = rot_dbl[2*WIDTH-1:WIDTH];
      endcase
   end

   // ------------------------------------------------------------------
   // Handshakes
   // ------------------------------------------------------------------
   assign clear    = rst_i || flush_i;
   assign ready_o  = (occ != FULL_OCC);
   assign head_rdy = vld[rd_ptr] && (cnt_mem[rd_ptr] == '0);
   assign push     = valid_i && ready_o;
   assign pop      = head_rdy && ready_i;

   assign valid_o     = head_rdy;
   assign result_o    = head_rdy ? res_mem[rd_ptr] : '0;
   assign tag_o       = head_rdy ? tag_mem[rd_ptr] : '0;
   assign occupancy_o = occ;

   // ------------------------------------------------------------------
   // Pointers and occupancy
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Entry valid bits and countdowns. Every valid entry counts down in
   // parallel, so a younger op waiting behind the head sits at zero and
   // releases the cycle after the head pops. Push and pop never hit the
   // same slot: pop needs a valid head, and push is blocked when full.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (clear) begin
         vld <= '0;
         for (int i = 0; i < DEPTH; i++) cnt_mem[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_ptr == PTR_W'(i))) begin
               vld[i]     <= 1'b1;
               cnt_mem[i] <= lat_i;
            end else begin
               if (pop && (rd_ptr == PTR_W'(i))) vld[i] <= 1'b0;
               if (vld[i] && (cnt_mem[i] != '0)) cnt_mem[i] <= cnt_mem[i] - 1'b1;
            end
         end
      end
   end

   // Payload storage needs no reset; it is only visible behind vld.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (push && (wr_ptr == PTR_W'(i))) begin
            res_mem[i] <= op_res;
            tag_mem[i] <= tag_i;
         end
      end
   end

endmodule

// File: tb/tb_dummy_accelerator_mq.sv
// tb_dummy_accelerator_mq
//    Directed bench for dummy_accelerator_mq. Inputs change and outputs are
//    sampled on the falling edge. The DUT acts on the rising edge.

module tb_dummy_accelerator_mq;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        valid_in;
   logic        ready_out;
   logic [31:0] rs1;
   logic [10:0] imm;
   logic [1:0]  op;
   logic [5:0]  lat;
   logic [7:0]  tag_in;
   logic        valid_out;
   logic        ready_in;
   logic [31:0] result;
   logic [7:0]  tag_out;
   logic [2:0]  occ;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [1:0] OP_XOR = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_ROTL = 2'b11;

   dummy_accelerator_mq dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .valid_i     (valid_in),
      .ready_o     (ready_out),
      .rs1_value_i (rs1),
      .imm_i       (imm),
      .op_i        (op),
      .lat_i       (lat),
      .tag_i       (tag_in),
      .valid_o     (valid_out),
      .ready_i     (ready_in),
      .result_o    (result),
      .tag_o       (tag_out),
      .occupancy_o (occ)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [1:0] o, input logic [31:0] r, input logic [10:0] i,
                        input logic [5:0] l, input logic [7:0] t);
      valid_in = 1'b1;
      op       = o;
      rs1      = r;
      imm      = i;
      lat      = l;
      tag_in   = t;
   endtask

   task automatic check_out(input string name, input logic v, input logic [31:0] r, input logic [7:0] t);
      check_eq({name, ".valid"},  valid_out, v);
      check_eq({name, ".result"}, result,    r);
      check_eq({name, ".tag"},    tag_out,   t);
   endtask

   initial begin
      int hits;
      rst = 1'b1; flush = 1'b0; ready_in = 1'b1;
      drive(OP_ADD, 32'h1111_1111, 11'h1, 6'd0, 8'hAA);
      @(negedge clk);

      // Reset held two cycles with a request pending
      step(); step();
      check_out("rst", 1'b0, 32'h0, 8'h0);
      check_eq("rst.ready", ready_out, 1'b1);
      check_eq("rst.occ",   occ, 3'd0);
      rst = 1'b0; valid_in = 1'b0;
      step();
      check_eq("rst.noaccept_occ", occ, 3'd0);
      check_eq("rst.noaccept_valid", valid_out, 1'b0);

      // Single XOR, lat=3: valid exactly 4 cycles after accept, for one cycle
      drive(OP_XOR, 32'hDEAD_BEEF, 11'h7FF, 6'd3, 8'h12);
      step();
      valid_in = 1'b0;
      check_eq("xor.occ1", occ, 3'd1);
      hits = 0;
      for (int k = 1; k <= 3; k++) begin
         if (valid_out) hits++;
         step();
      end
      check_eq("xor.early_valid", hits, 0);
      check_out("xor", 1'b1, 32'hDEAD_B910, 8'h12);
      step();
      check_eq("xor.after_valid", valid_out, 1'b0);
      check_eq("xor.after_occ", occ, 3'd0);

      // Ordering: long-latency A ahead of zero-latency B
      drive(OP_ADD, 32'hFFFF_FFFF, 11'h1, 6'd10, 8'h01);
      step();
      drive(OP_SUB, 32'h0, 11'h1, 6'd0, 8'h02);
      step();
      valid_in = 1'b0;
      check_eq("ord.occ2", occ, 3'd2);
      hits = 0;
      for (int k = 2; k <= 10; k++) begin
         if (valid_out) hits++;
         step();
      end
      check_eq("ord.early_valid", hits, 0);
      check_out("ord.A", 1'b1, 32'h0000_0000, 8'h01);
      step();
      check_out("ord.B", 1'b1, 32'hFFFF_FFFF, 8'h02);
      step();
      check_eq("ord.empty", valid_out, 1'b0);

      // Parallel countdown: B (lat=4) counts while waiting behind A (lat=4)
      drive(OP_XOR, 32'h0000_00F0, 11'h00F, 6'd4, 8'h0A);
      step();
      drive(OP_XOR, 32'h0000_0F00, 11'h0F0, 6'd4, 8'h0B);
      step();
      valid_in = 1'b0;
      step(); step(); step();
      check_out("par.A", 1'b1, 32'h0000_00FF, 8'h0A);
      step();
      check_out("par.B", 1'b1, 32'h0000_0FF0, 8'h0B);
      step();
      check_eq("par.empty", occ, 3'd0);

      // Full / backpressure
      ready_in = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive(OP_ADD, 32'(i) << 8, 11'(i), 6'd0, 8'h30 + 8'(i));
         step();
      end
      check_eq("full.ready", ready_out, 1'b0);
      check_eq("full.occ",   occ, 3'd4);
      drive(OP_ADD, 32'h500, 11'd5, 6'd0, 8'h35);
      step();
      check_eq("full.ignored_occ", occ, 3'd4);
      check_out("full.held1", 1'b1, 32'h101, 8'h31);
      ready_in = 1'b1;
      check_eq("full.ready_at_pop", ready_out, 1'b0);
      step();
      check_out("full.r2", 1'b1, 32'h202, 8'h32);
      check_eq("full.ready_after_pop", ready_out, 1'b1);
      check_eq("full.occ3", occ, 3'd3);
      step();
      valid_in = 1'b0;
      check_out("full.r3", 1'b1, 32'h303, 8'h33);
      check_eq("full.pushpop_occ", occ, 3'd3);
      step();
      check_out("full.r4", 1'b1, 32'h404, 8'h34);
      check_eq("full.occ2", occ, 3'd2);
      step();
      check_out("full.r5", 1'b1, 32'h505, 8'h35);
      step();
      check_eq("full.empty_valid", valid_out, 1'b0);
      check_eq("full.empty_occ", occ, 3'd0);

      // ROTL with output stall
      ready_in = 1'b0;
      drive(OP_ROTL, 32'h8000_0001, 11'h004, 6'd0, 8'h44);
      step();
      valid_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check_out("rotl.stall", 1'b1, 32'h0000_0018, 8'h44);
         step();
      end
      ready_in = 1'b1;
      check_out("rotl.pop", 1'b1, 32'h0000_0018, 8'h44);
      step();
      check_eq("rotl.after_valid", valid_out, 1'b0);
      check_eq("rotl.after_occ", occ, 3'd0);

      // Flush mid-flight
      for (int i = 0; i < 3; i++) begin
         drive(OP_ADD, 32'h1000, 11'(i), 6'd20, 8'h60 + 8'(i));
         step();
      end
      valid_in = 1'b0;
      check_eq("flush.occ_before", occ, 3'd3);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check_eq("flush.occ", occ, 3'd0);
      check_eq("flush.ready", ready_out, 1'b1);
      hits = 0;
      for (int k = 0; k < 25; k++) begin
         if (valid_out || occ != 3'd0) hits++;
         step();
      end
      check_eq("flush.no_output", hits, 0);
      drive(OP_XOR, 32'h1234_5678, 11'h0F0, 6'd2, 8'h55);
      step();
      valid_in = 1'b0;
      check_eq("flush.new_wait1", valid_out, 1'b0);
      step();
      check_eq("flush.new_wait2", valid_out, 1'b0);
      step();
      check_out("flush.new", 1'b1, 32'h1234_5688, 8'h55);
      step();
      check_eq("flush.new_done", occ, 3'd0);

      // Reset mid-flight discards the entry
      drive(OP_SUB, 32'h10, 11'h1, 6'd5, 8'h77);
      step();
      valid_in = 1'b0;
      check_eq("rstmid.occ_before", occ, 3'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("rstmid.occ", occ, 3'd0);
      hits = 0;
      for (int k = 0; k < 8; k++) begin
         if (valid_out) hits++;
         step();
      end
      check_eq("rstmid.no_output", hits, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
